// File: rtl/msi_bus_pkg.sv
// Shared types for the MSI snooping bus arbiter.
// Bus op encodings and arbiter FSM states.
package msi_bus_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    BUS_RD    = 2'b00,
    BUS_RDX   = 2'b01,
    BUS_UPGR  = 2'b10,
    BUS_FLUSH = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/msi_bus_arbiter_rr_pick.sv
// Round-robin winner select, combinational.
// Searches from last_grant+1 and wraps modulo NUM_REQ.
module rr_pick
  import msi_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_vld
);

  logic found;
  int   k;

  // first set request after the previous owner wins
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        win_oh[k] = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

  assign win_vld = |req;

endmodule

// File: rtl/msi_bus_arbiter.sv
// Round-robin arbiter / sequencer for the MSI bus.
// Optional WAIT timeout abort: ARB_TIMEOUT_EN.
module msi_bus_arbiter
  import msi_bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [OP_W*NUM_REQ-1:0]    req_op,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic                       bus_done,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       bus_valid,
  output logic [1:0]                 bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [$clog2(NUM_REQ)-1:0] bus_src,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         stall,
  output logic                       err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  bus_op_t            op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               err_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_q),
    .win_oh     (pick_oh),
    .win_idx    (pick_idx),
    .win_vld    (pick_vld)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
`endif

  // next-state and registered output computation
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = 1'b0;
    op_d    = op_q;
    addr_d  = addr_q;
    src_d   = src_q;
    ack_d   = '0;
    last_d  = last_q;
    err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_oh;
          src_d   = pick_idx;
          op_d    = bus_op_t'(
            req_op[OP_W*int'(pick_idx) +: OP_W]);
          addr_d  =
            req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
          valid_d = 1'b1;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        state_d = ARB_WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ARB_WAIT: begin
        if (bus_done) begin
          ack_d   = grant_q;
          state_d = ARB_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          ack_d   = grant_q;
          err_d   = 1'b1;
          state_d = ARB_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_RELEASE: begin
        last_d  = src_q;
        grant_d = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      op_q    <= BUS_RD;
      addr_q  <= '0;
      src_q   <= '0;
      ack_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // WAIT-cycle counter and abort flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = err_d ^ (TIMEOUT_CYC != 0);
  assign err = 1'b0;
`endif

  assign grant     = grant_q;
  assign bus_valid = valid_q;
  assign bus_op    = op_q;
  assign bus_addr  = addr_q;
  assign bus_src   = src_q;
  assign ack       = ack_q;
  assign stall     = req & ~ack_q;

endmodule
